// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver, scan strobed by clkSlow.
// Optional LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module seg7_scan_driver #(
  parameter int BLANK_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk100MHz,
  input  logic        rst,
  input  logic        clkSlow,
  input  logic        en,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  typedef enum logic {
    BLANK,
    SHOW
  } state_t;

  localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYCLES - 1);

  // Internal logic is active-low; these masks flip it for active-high pins.
  localparam logic [3:0] AN_X  = SEG_ACTIVE_LOW ? 4'h0 : 4'hf;
  localparam logic [6:0] SEG_X = SEG_ACTIVE_LOW ? 7'h00 : 7'h7f;
  localparam logic       DP_X  = ~SEG_ACTIVE_LOW;

  state_t      state;
  logic [1:0]  digit;
  logic [7:0]  blank_cnt;
  logic        slow_q;
  logic [15:0] shadow;
  logic [3:0]  shadow_dp;

  logic        tick;
  logic [3:0]  nib;
  logic [3:0]  show_an;
  logic [6:0]  show_seg;
  logic        show_dp;

  assign tick = clkSlow & ~slow_q;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    unique case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'ha: s = 7'b0001000;
      4'hb: s = 7'b0000011;
      4'hc: s = 7'b1000110;
      4'hd: s = 7'b0100001;
      4'he: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    unique case (digit)
      2'd0: nib = shadow[3:0];
      2'd1: nib = shadow[7:4];
      2'd2: nib = shadow[11:8];
      default: nib = shadow[15:12];
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [3:0] lz;

  always_comb begin
    lz[0] = 1'b0;
    lz[1] = shadow[15:4] == 12'h000;
    lz[2] = shadow[15:8] == 8'h00;
    lz[3] = shadow[15:12] == 4'h0;
  end
`endif

  always_comb begin
    show_an  = en ? ~(4'b0001 << digit) : 4'b1111;
    show_seg = hex7(nib);
    show_dp  = ~shadow_dp[digit];
`ifdef LEADING_ZERO_BLANK_EN
    // A requested dp keeps a leading-zero digit lit, dp only.
    if (lz[digit]) begin
      show_seg = 7'h7f;
      if (!shadow_dp[digit]) show_an = 4'b1111;
    end
`endif
  end

  always_ff @(posedge clk100MHz) begin
    if (rst) begin
      state     <= BLANK;
      digit     <= 2'd3;
      blank_cnt <= 8'd0;
      slow_q    <= 1'b0;
      shadow    <= 16'h0000;
      shadow_dp <= 4'b0000;
      an        <= 4'hf ^ AN_X;
      seg       <= 7'h7f ^ SEG_X;
      dp        <= 1'b1 ^ DP_X;
    end else begin
      slow_q <= clkSlow;
      unique case (state)
        BLANK: begin
          an  <= 4'hf ^ AN_X;
          seg <= 7'h7f ^ SEG_X;
          dp  <= 1'b1 ^ DP_X;
          if (blank_cnt == BLANK_LAST) begin
            state     <= SHOW;
            blank_cnt <= 8'd0;
            an        <= show_an ^ AN_X;
            seg       <= show_seg ^ SEG_X;
            dp        <= show_dp ^ DP_X;
          end else begin
            blank_cnt <= blank_cnt + 8'd1;
          end
        end
        default: begin
          if (tick) begin
            state <= BLANK;
            digit <= digit + 2'd1;
            an    <= 4'hf ^ AN_X;
            seg   <= 7'h7f ^ SEG_X;
            dp    <= 1'b1 ^ DP_X;
            // Whole frame uses one snapshot so digits never tear.
            if (digit == 2'd3) begin
              shadow    <= value;
              shadow_dp <= dp_in;
            end
          end else begin
            an  <= show_an ^ AN_X;
            seg <= show_seg ^ SEG_X;
            dp  <= show_dp ^ DP_X;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver; digit presentations are
// compared against a queue of hand-computed expectations.
module tb_seg7_scan_driver;

  localparam int B = 4;

  logic        clk100MHz = 1'b0;
  logic        rst = 1'b1;
  logic        clkSlow = 1'b0;
  logic        en = 1'b1;
  logic [15:0] value = 16'h12af;
  logic [3:0]  dp_in = 4'b0000;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t       q[$];
  int         total = 0;
  int         bad = 0;
  logic [3:0] prev_an = 4'h0;
  logic       lit;

  always #5 clk100MHz = ~clk100MHz;

  seg7_scan_driver #(
    .BLANK_CYCLES(B),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk100MHz(clk100MHz),
    .rst(rst),
    .clkSlow(clkSlow),
    .en(en),
    .value(value),
    .dp_in(dp_in),
    .an(an),
    .seg(seg),
    .dp(dp)
  );

  // Monitor: a digit presentation is an leaving the all-off state.
  always @(negedge clk100MHz) begin
    exp_t e;
    if (prev_an === 4'hf && an !== 4'hf) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_show: got an=%b seg=%b dp=%b, required none",
                 an, seg, dp);
      end else begin
        e = q.pop_front();
        if ({an, seg, dp} !== e) begin
          bad++;
          $display("FAIL show: got an=%b seg=%b dp=%b, required an=%b seg=%b dp=%b",
                   an, seg, dp, e.an, e.seg, e.dp);
        end
      end
    end
    prev_an = an;
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, got, req);
    end
  endtask

  task automatic push(input logic [3:0] a, input logic [6:0] s,
                      input logic d);
    exp_t e;
    e = {a, s, d};
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk100MHz);
    #2;
  endtask

  task automatic gap_check(input string nm);
    int n;
    n = 0;
    while (an === 4'hf && n < 100) begin
      n++;
      @(posedge clk100MHz);
      #1;
    end
    chk(nm, 32'(n), 32'(B));
  endtask

  task automatic tick(input bit gap);
    @(posedge clk100MHz);
    #2 clkSlow = 1'b1;
    @(posedge clk100MHz);
    #1 clkSlow = 1'b0;
    if (gap) gap_check("blank_gap");
  endtask

  initial begin
    // Post-reset: digit 3 of an all-zero shadow.
    push(4'b0111, 7'b1000000, 1'b1);
    repeat (3) begin
      @(posedge clk100MHz);
      #1;
      chk("reset_out", 32'({an, seg, dp}), 32'({4'hf, 7'h7f, 1'b1}));
    end
    rst = 1'b0;
    gap_check("reset_blank");
    idle(50);

    // Frame of 12AF.
    push(4'b1110, 7'b0001110, 1'b1); tick(1'b1); idle(50);
    push(4'b1101, 7'b0001000, 1'b1); tick(1'b1); idle(50);
    push(4'b1011, 7'b0100100, 1'b1); tick(1'b1); idle(50);
    push(4'b0111, 7'b1111001, 1'b1); tick(1'b1); idle(50);

    // Value change mid-frame must not tear.
    value = 16'h1234;
    push(4'b1110, 7'b0011001, 1'b1); tick(1'b1); idle(50);
    push(4'b1101, 7'b0110000, 1'b1); tick(1'b1); idle(10);
    value = 16'h5678;
    idle(40);
    push(4'b1011, 7'b0100100, 1'b1); tick(1'b1); idle(50);
    push(4'b0111, 7'b1111001, 1'b1); tick(1'b1); idle(50);
    push(4'b1110, 7'b0000000, 1'b1); tick(1'b1); idle(50);

    // Second edge lands inside BLANK and is dropped.
    push(4'b1101, 7'b1111000, 1'b1);
    @(posedge clk100MHz); #2 clkSlow = 1'b1;
    @(posedge clk100MHz); #2 clkSlow = 1'b0;
    @(posedge clk100MHz); #2 clkSlow = 1'b1;
    @(posedge clk100MHz); #2 clkSlow = 1'b0;
    idle(50);
    push(4'b1011, 7'b0000010, 1'b1); tick(1'b1); idle(50);

    // Disabled for a full frame; scan keeps running underneath.
    en = 1'b0;
    lit = 1'b0;
    idle(2);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0);
      repeat (50) begin
        @(posedge clk100MHz);
        #1;
        if (an !== 4'hf) lit = 1'b1;
      end
    end
    chk("en_off", 32'(lit), 32'(0));
    #1 en = 1'b1;
    push(4'b1011, 7'b0000010, 1'b1);
    @(posedge clk100MHz);
    #1;
    chk("en_on", 32'(an), 32'(4'b1011));
    idle(50);

    // 0040 with dp on digit 3.
    value = 16'h0040;
    dp_in = 4'b1000;
    push(4'b0111, 7'b0010010, 1'b1); tick(1'b1); idle(50);
    push(4'b1110, 7'b1000000, 1'b1); tick(1'b1); idle(50);
    push(4'b1101, 7'b0011001, 1'b1); tick(1'b1); idle(50);
`ifdef LEADING_ZERO_BLANK_EN
    tick(1'b0);
    idle(50);
    chk("lzb_dig2_off", 32'({an, seg}), 32'({4'hf, 7'h7f}));
    push(4'b0111, 7'b1111111, 1'b0); tick(1'b1); idle(50);
`else
    push(4'b1011, 7'b1000000, 1'b1); tick(1'b1); idle(50);
    push(4'b0111, 7'b1000000, 1'b0); tick(1'b1); idle(50);
`endif

    chk("queue_empty", 32'(q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
